if_stage_sram_like: RTL and testbench
=====================================

# if_stage_sram_like

Instruction-fetch stage that talks to instruction memory over the split-handshake SRAM-like interface (req/addr_ok, then data_ok) instead of a fixed-latency synchronous SRAM. It sits between the PC redirect sources (ID branch bus, WB exception/ertn flush) and the decode stage. A parametrised instruction buffer decouples memory latency from decode back-pressure. Redirects cancel in-flight requests, so stale instructions never reach decode. Misaligned fetch addresses are reported as an ADEF fault.

## Interface
Parameters:
- `RESET_PC`, 32'h1c000000, first fetch address after reset
- `IBUF_DEPTH`, 2, instruction-buffer entries (power of two, ≥2)

Ports (one clock; reset is synchronous, active-high):
- `clk` in 1 — clock
- `reset` in 1 — synchronous active-high reset
- `ds_allowin` in 1 — decode accepts an entry this cycle
- `fs_to_ds_valid` out 1 — buffer head valid
- `fs_to_ds_bus` out `FS_TO_DS_BUS_WD` (65) — {adef, pc[31:0], inst[31:0]}
- `brbus` in `BR_BUS_WD` (33) — {br_taken, br_target}
- `flush` in 1 — WB exception/ertn redirect
- `flush_pc` in 32 — redirect target for `flush`
- `inst_sram_req` out 1, `inst_sram_wr` out 1 (const 0), `inst_sram_size` out 2 (const 2'b10), `inst_sram_wstrb` out 4 (const 0), `inst_sram_addr` out 32, `inst_sram_wdata` out 32 (const 0)
- `inst_sram_addr_ok` in 1, `inst_sram_data_ok` in 1, `inst_sram_rdata` in 32

## Operation
- State: `fetch_pc` (next address), `outstanding` (1 request accepted, data pending), `out_pc`, `discard`, `halt`, IBUF (count, head, tail).
- At most one outstanding request.
- `pop = fs_to_ds_valid && ds_allowin`.
- `room = (count + outstanding - pop) < IBUF_DEPTH`.
- Request: `inst_sram_req = !reset && !halt && fetch_pc[1:0]==0 && (!outstanding || data_ok) && room`. `inst_sram_addr = fetch_pc`.
- `req && addr_ok`: set `outstanding`, `out_pc <= fetch_pc`, `fetch_pc <= fetch_pc+4` (unless a redirect occurs the same cycle).
- `data_ok` with `outstanding`:
  - clear `outstanding` (unless a new accept occurs the same cycle);
  - if `discard`: drop the data and clear `discard`;
  - else push {0, out_pc, rdata}.
- `data_ok` with no outstanding request: ignored.
- Misaligned `fetch_pc`:
  - no request is issued;
  - once `!outstanding && room`, push {1, fetch_pc, 32'h0} and set `halt`.
  - `halt` holds until the next redirect.
- Redirect: `flush` takes priority over `br_taken`; the target is `flush_pc` or `br_target`. In the redirect cycle:
  - `fetch_pc <= target`; IBUF cleared (pushes and pops that cycle are ignored); `halt` cleared;
  - if a request is outstanding and not completing this cycle, set `discard`;
  - if `req && addr_ok` this cycle, set `outstanding`, set `discard`, and leave `fetch_pc` at the target;
  - if `data_ok` this cycle, the data is dropped.
- `fs_to_ds_valid = count!=0 && !flush && !br_taken`. `br_taken` must not combinationally depend on `fs_to_ds_valid`.
- Bus output is the IBUF head entry (registered storage).

## Timing
- Reset values:
  - `inst_sram_req` = 0, `fs_to_ds_valid` = 0, IBUF empty;
  - `outstanding`, `discard`, `halt` = 0;
  - `fetch_pc` = `RESET_PC`.
- First request is asserted in the first cycle with `reset` low.
- Reset mid-transaction clears all state; a late `data_ok` after reset is ignored because `outstanding` = 0.
- `data_ok` in cycle k → `fs_to_ds_valid` in cycle k+1.
- With `addr_ok` tied 1, `data_ok` one cycle after accept, and `ds_allowin` tied 1, throughput is 1 instr/cycle.
- `req` is combinational and may drop without `addr_ok` only on a redirect or when `room` falls.
- IBUF pointers wrap modulo `IBUF_DEPTH`. Push and pop in the same cycle with IBUF full is legal and leaves `count` unchanged.

## Structure
- `mycpu.vh` defines `FS_TO_DS_BUS_WD` (65), `BR_BUS_WD` (33) and `FS_ADEF_BIT` (64).
- Sub-module `fs_ibuf`: synchronous FIFO with parameters WIDTH and DEPTH, ports push/pop/clear, outputs empty/count/head. `clear` has priority over push and pop.
- The top level holds the PC, the request/discard logic and the output gating.

## Test plan
- Reset release, with `addr_ok`=1 and `data_ok` one cycle later, `ds_allowin`=1 → addresses 1c000000, 1c000004, 1c000008 issued on consecutive cycles; bus pcs arrive in order, one per cycle.
- `ds_allowin`=0 for 5 cycles, `IBUF_DEPTH`=2 → at most 2 entries buffered and `req` deasserts. On release, entries drain in order with none lost or duplicated.
- Outstanding request to 1c000010 with `data_ok` delayed 3 cycles; `br_taken`=1 with target 1c000100 in between → returning data dropped; next delivered pc = 1c000100.
- `flush` and `br_taken` in the same cycle, `flush_pc`=1c001000 and `br_target`=1c000200 → next pc = 1c001000; IBUF emptied; `fs_to_ds_valid`=0 that cycle.
- Redirect to 1c000102 → no request issued; one entry delivered with adef=1, pc=1c000102, inst=0; `req` stays 0 until a flush to 1c000000 resumes fetching.
- Redirect in the same cycle as `req && addr_ok` → that request's data is discarded, and the next request goes to the target.

Source files
------------

// File: rtl/if_stage_sram_like_pkg.sv
// Shared widths, the decode-bound entry layout and small helpers for the
// SRAM-like instruction-fetch stage.
package if_stage_sram_like_pkg;

    localparam int FS_TO_DS_BUS_WD = 65;
    localparam int BR_BUS_WD       = 33;
    localparam int FS_ADEF_BIT     = 64;

    // Bit layout matches the decode bus: {adef, pc, inst}.
    typedef struct packed {
        logic        adef;
        logic [31:0] pc;
        logic [31:0] inst;
    } fs_entry_t;

    function automatic logic is_misaligned(input logic [31:0] pc);
        return pc[1:0] != 2'b00;
    endfunction

endpackage

// File: rtl/fs_ibuf.sv
// Small synchronous FIFO between instruction memory and decode; clear wins
// over push and pop so a redirect leaves it empty on the next cycle.
module fs_ibuf #(
    parameter int WIDTH = 65,
    parameter int DEPTH = 2,
    localparam int CNT_W = $clog2(DEPTH + 1),
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic             clear,
    input  logic [WIDTH-1:0] din,
    output logic             empty,
    output logic [CNT_W-1:0] count,
    output logic [WIDTH-1:0] head
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push, do_pop;

    // A push into a full buffer is only accepted when the head leaves this cycle.
    assign do_pop  = pop && (count_q != '0);
    assign do_push = push && ((count_q != CNT_W'(DEPTH)) || do_pop);

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (clear) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (do_pop)  head_d = head_q + PTR_W'(1);
            if (do_push) tail_d = tail_q + PTR_W'(1);
            count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !clear) mem_q[tail_q] <= din;
    end

    assign empty = (count_q == '0);
    assign count = count_q;
    assign head  = mem_q[head_q];

endmodule

// File: rtl/if_stage_sram_like.sv
// Instruction-fetch stage on a split req/addr_ok + data_ok memory port, with
// redirect cancellation and an instruction buffer towards decode.
module if_stage_sram_like
    import if_stage_sram_like_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = 32'h1c000000,
    parameter int          IBUF_DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       ds_allowin,
    output logic                       fs_to_ds_valid,
    output logic [FS_TO_DS_BUS_WD-1:0] fs_to_ds_bus,
    input  logic [BR_BUS_WD-1:0]       brbus,
    input  logic                       flush,
    input  logic [31:0]                flush_pc,
    output logic                       inst_sram_req,
    output logic                       inst_sram_wr,
    output logic [1:0]                 inst_sram_size,
    output logic [3:0]                 inst_sram_wstrb,
    output logic [31:0]                inst_sram_addr,
    output logic [31:0]                inst_sram_wdata,
    input  logic                       inst_sram_addr_ok,
    input  logic                       inst_sram_data_ok,
    input  logic [31:0]                inst_sram_rdata
);

    localparam int CNT_W = $clog2(IBUF_DEPTH + 1);

    logic        br_taken;
    logic [31:0] br_target;
    logic        redirect;
    logic [31:0] redirect_pc;

    logic [31:0] fetch_pc_q, fetch_pc_d;
    logic [31:0] out_pc_q, out_pc_d;
    logic        outstanding_q, outstanding_d;
    logic        discard_q, discard_d;
    logic        halt_q, halt_d;

    logic [CNT_W-1:0] ib_count;
    logic             ib_empty;
    logic             ib_push;
    fs_entry_t        ib_din, ib_head;

    logic [CNT_W:0] occupancy;
    logic           pop, room, misaligned, accept, resp, push_inst, push_adef;

    assign {br_taken, br_target} = brbus;
    assign redirect    = flush || br_taken;
    assign redirect_pc = flush ? flush_pc : br_target;

    assign pop        = fs_to_ds_valid && ds_allowin;
    // Count the in-flight request as already occupying a slot so its data always fits.
    assign occupancy  = {1'b0, ib_count} + (CNT_W+1)'(outstanding_q) - (CNT_W+1)'(pop);
    assign room       = occupancy < (CNT_W+1)'(IBUF_DEPTH);
    assign misaligned = is_misaligned(fetch_pc_q);

    assign inst_sram_req   = !reset && !halt_q && !misaligned
                             && (!outstanding_q || inst_sram_data_ok) && room;
    assign inst_sram_addr  = fetch_pc_q;
    assign inst_sram_wr    = 1'b0;
    assign inst_sram_size  = 2'b10;
    assign inst_sram_wstrb = 4'b0000;
    assign inst_sram_wdata = 32'h0;

    assign accept    = inst_sram_req && inst_sram_addr_ok;
    assign resp      = inst_sram_data_ok && outstanding_q;
    assign push_inst = resp && !discard_q;
    assign push_adef = misaligned && !halt_q && !outstanding_q && room;
    assign ib_push   = push_inst || push_adef;

    always_comb begin
        ib_din = '{adef: 1'b0, pc: out_pc_q, inst: inst_sram_rdata};
        if (push_adef) ib_din = '{adef: 1'b1, pc: fetch_pc_q, inst: 32'h0};
    end

    always_comb begin
        fetch_pc_d    = fetch_pc_q;
        out_pc_d      = out_pc_q;
        outstanding_d = outstanding_q;
        discard_d     = discard_q;
        halt_d        = halt_q;
        if (accept) begin
            outstanding_d = 1'b1;
            out_pc_d      = fetch_pc_q;
            fetch_pc_d    = fetch_pc_q + 32'd4;
        end else if (resp) begin
            outstanding_d = 1'b0;
        end
        if (resp) discard_d = 1'b0;
        if (push_adef) halt_d = 1'b1;
        // Anything still in flight past a redirect belongs to the old path.
        if (redirect) begin
            fetch_pc_d = redirect_pc;
            halt_d     = 1'b0;
            discard_d  = accept || (outstanding_q && !inst_sram_data_ok);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_pc_q    <= RESET_PC;
            outstanding_q <= 1'b0;
            discard_q     <= 1'b0;
            halt_q        <= 1'b0;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            outstanding_q <= outstanding_d;
            discard_q     <= discard_d;
            halt_q        <= halt_d;
        end
    end

    always_ff @(posedge clk) begin
        out_pc_q <= out_pc_d;
    end

    fs_ibuf #(
        .WIDTH (FS_TO_DS_BUS_WD),
        .DEPTH (IBUF_DEPTH)
    ) u_ibuf (
        .clk   (clk),
        .reset (reset),
        .push  (ib_push),
        .pop   (pop),
        .clear (redirect),
        .din   (ib_din),
        .empty (ib_empty),
        .count (ib_count),
        .head  (ib_head)
    );

    assign fs_to_ds_valid = !ib_empty && !redirect;
    assign fs_to_ds_bus   = ib_head;

endmodule

// File: tb/tb_if_stage_sram_like.sv
// Bench for if_stage_sram_like: a latency-programmable memory responder plus
// a scoreboard of expected decode entries checked on every accepted pop.
module tb_if_stage_sram_like;
    import if_stage_sram_like_pkg::*;

    localparam logic [31:0] RESET_PC = 32'h1c000000;

    logic        clk;
    logic        reset;
    logic        ds_allowin;
    logic        fs_to_ds_valid;
    logic [64:0] fs_to_ds_bus;
    logic [32:0] brbus;
    logic        flush;
    logic [31:0] flush_pc;
    logic        inst_sram_req, inst_sram_wr;
    logic [1:0]  inst_sram_size;
    logic [3:0]  inst_sram_wstrb;
    logic [31:0] inst_sram_addr, inst_sram_wdata;
    logic        inst_sram_addr_ok, inst_sram_data_ok;
    logic [31:0] inst_sram_rdata;

    if_stage_sram_like #(.RESET_PC(RESET_PC), .IBUF_DEPTH(2)) dut (
        .clk               (clk),
        .reset             (reset),
        .ds_allowin        (ds_allowin),
        .fs_to_ds_valid    (fs_to_ds_valid),
        .fs_to_ds_bus      (fs_to_ds_bus),
        .brbus             (brbus),
        .flush             (flush),
        .flush_pc          (flush_pc),
        .inst_sram_req     (inst_sram_req),
        .inst_sram_wr      (inst_sram_wr),
        .inst_sram_size    (inst_sram_size),
        .inst_sram_wstrb   (inst_sram_wstrb),
        .inst_sram_addr    (inst_sram_addr),
        .inst_sram_wdata   (inst_sram_wdata),
        .inst_sram_addr_ok (inst_sram_addr_ok),
        .inst_sram_data_ok (inst_sram_data_ok),
        .inst_sram_rdata   (inst_sram_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } pend_t;

    pend_t       pend[$];
    logic [64:0] sb[$];
    logic [31:0] acc_addr[$];
    int          acc_cyc[$];
    int          pop_cycles[$];

    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    int   lat = 1;
    int   pops_total = 0;
    int   pop_target = 0;
    logic snap_req, snap_valid;
    logic [31:0] snap_addr;

    task automatic chk(input string tag, input logic [64:0] obs, input logic [64:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] inst_of(input logic [31:0] a);
        return {a[15:0], ~a[31:16]};
    endfunction

    function automatic logic [64:0] ent(input logic adef, input logic [31:0] pc, input logic [31:0] inst);
        return {adef, pc, inst};
    endfunction

    task automatic push_stream(input logic [31:0] base, input int n);
        for (int i = 0; i < n; i++) sb.push_back(ent(1'b0, base + 32'(4*i), inst_of(base + 32'(4*i))));
        pop_target += n;
    endtask

    // One clock: memory response, accept logging and scoreboard compare at negedge.
    task automatic tick();
        logic [64:0] exp_e;
        ds_allowin = (pops_total < pop_target);
        @(negedge clk);
        if (pend.size() != 0 && pend[0].due <= cyc) begin
            inst_sram_data_ok = 1'b1;
            inst_sram_rdata   = inst_of(pend[0].addr);
        end else begin
            inst_sram_data_ok = 1'b0;
            inst_sram_rdata   = $urandom;
        end
        #1;
        snap_req   = inst_sram_req;
        snap_addr  = inst_sram_addr;
        snap_valid = fs_to_ds_valid;
        if (inst_sram_data_ok) void'(pend.pop_front());
        if (inst_sram_req && inst_sram_addr_ok) begin
            pend.push_back('{inst_sram_addr, cyc + lat});
            acc_addr.push_back(inst_sram_addr);
            acc_cyc.push_back(cyc);
        end
        if (fs_to_ds_valid && ds_allowin) begin
            if (sb.size() != 0) exp_e = sb.pop_front();
            else exp_e = {1'b1, 32'hdeaddead, 32'hdeaddead};
            chk("bus", fs_to_ds_bus, exp_e);
            pops_total++;
            pop_cycles.push_back(cyc);
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic drain(input string tag, input int budget);
        int n = 0;
        while (pops_total < pop_target && n < budget) begin
            tick();
            n++;
        end
        chk({tag, "_pops"}, 65'(pops_total), 65'(pop_target));
        chk({tag, "_sb_empty"}, 65'(sb.size()), 65'd0);
    endtask

    initial begin
        int rel, mark, idx, acc0;
        reset             = 1'b1;
        ds_allowin        = 1'b0;
        brbus             = '0;
        flush             = 1'b0;
        flush_pc          = '0;
        inst_sram_addr_ok = 1'b1;
        inst_sram_data_ok = 1'b0;
        inst_sram_rdata   = '0;

        // Reset holds everything quiet.
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("rst_req", 65'(snap_req), 65'd0);
            chk("rst_valid", 65'(snap_valid), 65'd0);
        end

        // Sequential streaming at one instruction per cycle.
        reset = 1'b0;
        rel = cyc;
        push_stream(RESET_PC, 8);
        drain("s1", 40);
        chk("s1_addr0", 65'(acc_addr[0]), 65'(32'h1c000000));
        chk("s1_addr1", 65'(acc_addr[1]), 65'(32'h1c000004));
        chk("s1_addr2", 65'(acc_addr[2]), 65'(32'h1c000008));
        chk("s1_first_req_cyc", 65'(acc_cyc[0] - rel), 65'd0);
        chk("s1_b2b_req", 65'(acc_cyc[2] - acc_cyc[0]), 65'd2);
        chk("s1_first_pop_cyc", 65'(pop_cycles[0] - rel), 65'd2);
        chk("s1_throughput", 65'(pop_cycles[7] - pop_cycles[0]), 65'd7);

        // Decode back-pressure: buffer fills to depth and requests stop.
        idle(5);
        chk("s2_req_stalled", 65'(snap_req), 65'd0);
        chk("s2_inflight", 65'(acc_addr.size() - pops_total), 65'd2);
        mark = cyc;
        push_stream(32'h1c000020, 6);
        drain("s2", 30);
        chk("s2_drain_immediate", 65'(pop_cycles[8] - mark), 65'd0);

        // Branch while a slow request is outstanding: its data is dropped.
        idle(3);
        lat = 3;
        flush = 1'b1; flush_pc = 32'h1c000010;
        tick();
        flush = 1'b0;
        mark = cyc;
        tick();
        chk("s3_req", 65'(snap_req), 65'd1);
        chk("s3_addr", 65'(snap_addr), 65'(32'h1c000010));
        push_stream(32'h1c000100, 2);
        brbus = {1'b1, 32'h1c000100};
        tick();
        brbus = '0;
        idx = pops_total;
        drain("s3", 30);
        chk("s3_lat", 65'(pop_cycles[idx] - mark), 65'd7);
        lat = 1;

        // Flush and branch together: flush wins, stale entries vanish.
        idle(3);
        push_stream(32'h1c001000, 3);
        flush = 1'b1; flush_pc = 32'h1c001000;
        brbus = {1'b1, 32'h1c000200};
        tick();
        chk("s4_valid_gated", 65'(snap_valid), 65'd0);
        flush = 1'b0; brbus = '0;
        drain("s4", 30);

        // Misaligned target: one ADEF entry, then fetching halts until a flush.
        idle(3);
        sb.push_back(ent(1'b1, 32'h1c000102, 32'h0));
        pop_target += 1;
        brbus = {1'b1, 32'h1c000102};
        tick();
        brbus = '0;
        drain("s5", 20);
        acc0 = acc_addr.size();
        idle(6);
        chk("s5_halt_req", 65'(snap_req), 65'd0);
        chk("s5_halt_noacc", 65'(acc_addr.size() - acc0), 65'd0);
        push_stream(32'h1c000000, 2);
        flush = 1'b1; flush_pc = 32'h1c000000;
        tick();
        flush = 1'b0;
        drain("s5r", 20);

        // Redirect in the same cycle a request is accepted.
        idle(3);
        flush = 1'b1; flush_pc = 32'h1c000400;
        tick();
        flush = 1'b0;
        push_stream(32'h1c000300, 2);
        brbus = {1'b1, 32'h1c000300};
        idx = acc_addr.size();
        tick();
        brbus = '0;
        chk("s6_req_in_redirect", 65'(snap_req), 65'd1);
        chk("s6_addr_in_redirect", 65'(snap_addr), 65'(32'h1c000400));
        drain("s6", 20);
        chk("s6_next_addr", 65'((acc_addr.size() > idx + 1) ? acc_addr[idx+1] : 32'h0), 65'(32'h1c000300));

        // Reset mid-transaction: the late response is ignored.
        idle(3);
        flush = 1'b1; flush_pc = 32'h1c000500;
        tick();
        flush = 1'b0;
        lat = 3;
        tick();
        chk("s7_acc", 65'(snap_addr), 65'(32'h1c000500));
        lat = 1;
        reset = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            chk("s7_rst_req", 65'(snap_req), 65'd0);
            chk("s7_rst_valid", 65'(snap_valid), 65'd0);
        end
        reset = 1'b0;
        push_stream(RESET_PC, 2);
        tick();
        chk("s7_restart_req", 65'(snap_req), 65'd1);
        chk("s7_restart_addr", 65'(snap_addr), 65'(RESET_PC));
        drain("s7", 20);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
